// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer: one state per datapath step, with a
// memory handshake that waits for ready and traps on a bounded timeout.
module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_in,
    input  logic [5:0] func_in,
    input  logic       zero_in,
    input  logic       mem_ready_in,
    output logic       pcWrite_out,
    output logic       IorD_out,
    output logic       memRead_out,
    output logic       memWrite_out,
    output logic       irWrite_out,
    output logic       regDst_out,
    output logic       memToReg_out,
    output logic       regWrite_out,
    output logic       ALUSrcA_out,
    output logic [1:0] ALUSrcB_out,
    output logic       extCntrl_out,
    output logic [3:0] ALUCntrl_out,
    output logic       PCSource_out,
    output logic       retire_out,
    output logic [1:0] trap_out,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        R_WB     = 4'd4,
        EXEC_I   = 4'd5,
        I_WB     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_LUI = 4'b1111;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_next;
    logic [1:0] trap_next;
    logic       mem_state;
    logic       timeout;

    function automatic logic [3:0] r_alu(input logic [5:0] func);
        case (func)
            FN_SUB:  r_alu = ALU_SUB;
            FN_SLT:  r_alu = ALU_SLT;
            FN_NOR:  r_alu = ALU_NOR;
            default: r_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            trap_out <= TRAP_NONE;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            trap_out <= trap_next;
        end
    end

    assign state_out = state;
    assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // Timeout fires on the cycle the count would reach the limit; ready that same cycle wins.
    assign timeout   = mem_state && !mem_ready_in &&
                       (({1'b0, wait_cnt} + 9'd1) == 9'(MEM_TIMEOUT));

    always_comb begin
        state_next   = state;
        trap_next    = trap_out;
        wait_next    = (mem_state && !mem_ready_in && !timeout) ? wait_cnt + 8'd1 : 8'd0;
        pcWrite_out  = 1'b0;
        IorD_out     = 1'b0;
        memRead_out  = 1'b0;
        memWrite_out = 1'b0;
        irWrite_out  = 1'b0;
        regDst_out   = 1'b0;
        memToReg_out = 1'b0;
        regWrite_out = 1'b0;
        ALUSrcA_out  = 1'b0;
        ALUSrcB_out  = 2'b00;
        extCntrl_out = 1'b0;
        ALUCntrl_out = ALU_ADD;
        PCSource_out = 1'b0;
        retire_out   = 1'b0;

        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                memRead_out = 1'b1;
                ALUSrcB_out = 2'b01;
                if (timeout) begin
                    state_next = TRAP;
                    trap_next  = TRAP_TIMEOUT;
                end else if (mem_ready_in) begin
                    irWrite_out = 1'b1;
                    pcWrite_out = 1'b1;
                    state_next  = DECODE;
                end
            end
            DECODE: begin
                // Branch target is computed speculatively while the opcode is decoded.
                ALUSrcB_out  = 2'b11;
                extCntrl_out = 1'b1;
                case (op_in)
                    OP_RTYPE: begin
                        if (func_in == FN_NOP) begin
                            retire_out = 1'b1;
                            state_next = FETCH;
                        end else if (func_in == FN_ADD || func_in == FN_SUB ||
                                     func_in == FN_SLT || func_in == FN_NOR) begin
                            state_next = EXEC_R;
                        end else begin
                            state_next = TRAP;
                            trap_next  = TRAP_ILLEGAL;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_LUI: state_next = EXEC_I;
                    OP_LW, OP_SW:             state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE:           state_next = BRANCH;
                    default: begin
                        state_next = TRAP;
                        trap_next  = TRAP_ILLEGAL;
                    end
                endcase
            end
            EXEC_R: begin
                ALUSrcA_out  = 1'b1;
                ALUCntrl_out = r_alu(func_in);
                state_next   = R_WB;
            end
            R_WB: begin
                regDst_out   = 1'b1;
                regWrite_out = 1'b1;
                ALUCntrl_out = r_alu(func_in);
                retire_out   = 1'b1;
                state_next   = FETCH;
            end
            EXEC_I: begin
                ALUSrcA_out = 1'b1;
                ALUSrcB_out = 2'b10;
                case (op_in)
                    OP_ANDI: ALUCntrl_out = ALU_AND;
                    OP_LUI:  ALUCntrl_out = ALU_LUI;
                    default: extCntrl_out = 1'b1;
                endcase
                state_next = I_WB;
            end
            I_WB: begin
                regWrite_out = 1'b1;
                retire_out   = 1'b1;
                state_next   = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA_out  = 1'b1;
                ALUSrcB_out  = 2'b10;
                extCntrl_out = 1'b1;
                state_next   = (op_in == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                IorD_out    = 1'b1;
                memRead_out = 1'b1;
                if (timeout) begin
                    state_next = TRAP;
                    trap_next  = TRAP_TIMEOUT;
                end else if (mem_ready_in) begin
                    state_next = MEM_WB;
                end
            end
            MEM_WB: begin
                memToReg_out = 1'b1;
                regWrite_out = 1'b1;
                retire_out   = 1'b1;
                state_next   = FETCH;
            end
            MEM_WR: begin
                IorD_out     = 1'b1;
                memWrite_out = 1'b1;
                if (timeout) begin
                    state_next = TRAP;
                    trap_next  = TRAP_TIMEOUT;
                end else if (mem_ready_in) begin
                    retire_out = 1'b1;
                    state_next = FETCH;
                end
            end
            BRANCH: begin
                ALUSrcA_out  = 1'b1;
                ALUCntrl_out = ALU_SUB;
                PCSource_out = 1'b1;
                retire_out   = 1'b1;
                pcWrite_out  = (op_in == OP_BEQ) ? zero_in : ~zero_in;
                state_next   = FETCH;
            end
            TRAP: state_next = TRAP;
            default: state_next = TRAP;
        endcase
    end

endmodule
